// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: instruction RAM request/response plus the fetch->decode handshake.
// master = fetch stage, slave = RAM/decode side.
`ifndef INST_RAM_WIDTH
`define INST_RAM_WIDTH 12
`endif
`ifndef PROG_TYPE_WIDTH
`define PROG_TYPE_WIDTH 2
`endif

interface inst_fetch_if #(
  parameter int ADDR_W = `INST_RAM_WIDTH
) ();
  logic [`PROG_TYPE_WIDTH-1:0] ram_prog_type;
  logic                        re;
  logic [ADDR_W-1:0]           read_addr;
  logic [31:0]                 read_data;
  logic                        read_finished;
  logic [31:0]                 inst;
  logic [ADDR_W-1:0]           inst_pc;
  logic                        inst_valid;
  logic                        inst_ready;

  modport master (
    output ram_prog_type, re, read_addr, inst, inst_pc, inst_valid,
    input  read_data, read_finished, inst_ready
  );

  modport slave (
    input  ram_prog_type, re, read_addr, inst, inst_pc, inst_valid,
    output read_data, read_finished, inst_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, RAM read request, valid/ready delivery to decode.
// Optional halt-on-0x00000073 behaviour is enabled with `define FETCH_HALT_EN.
`ifndef INST_RAM_WIDTH
`define INST_RAM_WIDTH 12
`endif
`ifndef PROG_TYPE_WIDTH
`define PROG_TYPE_WIDTH 2
`endif

module inst_fetch #(
  parameter int                ADDR_W   = `INST_RAM_WIDTH,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        run,
  input  logic [`PROG_TYPE_WIDTH-1:0] prog_type,
  input  logic                        redirect_valid,
  input  logic [ADDR_W-1:0]           redirect_pc,
  output logic                        halted,
  inst_fetch_if.master                bus
);

  typedef enum logic [1:0] {IDLE, REQ, VALID} state_t;

  state_t                        state_q, state_d;
  logic [ADDR_W-1:0]             pc_q, pc_d;
  logic [ADDR_W-1:0]             inst_pc_q, inst_pc_d;
  logic [31:0]                   inst_q, inst_d;
  logic                          re_q, re_d;
  logic                          inst_valid_q, inst_valid_d;
  logic [`PROG_TYPE_WIDTH-1:0]   ram_prog_type_q, ram_prog_type_d;
  logic                          prog_switch;
  logic                          halt_hit;
  logic                          halted_q;

  assign prog_switch = (prog_type != ram_prog_type_q);

`ifdef FETCH_HALT_EN
  localparam logic [31:0] HALT_WORD = 32'h0000_0073;
  logic halted_d;

  assign halt_hit = (state_q == VALID) && bus.inst_ready && (inst_q == HALT_WORD);

  always_comb begin
    halted_d = halted_q;
    if (prog_switch || redirect_valid)
      halted_d = 1'b0;
    else if (halt_hit)
      halted_d = 1'b1;
  end
`else
  assign halt_hit = 1'b0;
  assign halted_q = 1'b0;
`endif

  // Flushes (program switch, redirect) override whatever the FSM was doing,
  // including a read completing or an instruction being accepted that cycle.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    inst_d          = inst_q;
    inst_pc_d       = inst_pc_q;
    ram_prog_type_d = ram_prog_type_q;

    if (prog_switch) begin
      ram_prog_type_d = prog_type;
      pc_d            = RESET_PC;
      state_d         = IDLE;
    end else if (redirect_valid) begin
      pc_d    = redirect_pc & ~ADDR_W'(3);
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (run && !halted_q)
            state_d = REQ;
        end
        REQ: begin
          if (bus.read_finished) begin
            inst_d    = bus.read_data;
            inst_pc_d = pc_q;
            state_d   = VALID;
          end
        end
        VALID: begin
          if (bus.inst_ready) begin
            if (halt_hit) begin
              state_d = IDLE;
            end else begin
              pc_d    = pc_q + ADDR_W'(4);
              state_d = run ? REQ : IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    re_d         = (state_d == REQ);
    inst_valid_d = (state_d == VALID);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q         <= IDLE;
      pc_q            <= RESET_PC;
      inst_q          <= '0;
      inst_pc_q       <= '0;
      re_q            <= 1'b0;
      inst_valid_q    <= 1'b0;
      ram_prog_type_q <= '0;
`ifdef FETCH_HALT_EN
      halted_q        <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      inst_q          <= inst_d;
      inst_pc_q       <= inst_pc_d;
      re_q            <= re_d;
      inst_valid_q    <= inst_valid_d;
      ram_prog_type_q <= ram_prog_type_d;
`ifdef FETCH_HALT_EN
      halted_q        <= halted_d;
`endif
    end
  end

  assign bus.re            = re_q;
  assign bus.read_addr     = pc_q;
  assign bus.inst          = inst_q;
  assign bus.inst_pc       = inst_pc_q;
  assign bus.inst_valid    = inst_valid_q;
  assign bus.ram_prog_type = ram_prog_type_q;
  assign halted            = halted_q;

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction fetch stage sitting directly upstream of the instruction RAM and downstream into decode. Holds the PC, drives the RAM read request (re/read_addr), captures the 32-bit word on read_finished, and presents it to decode with a valid/ready handshake. Handles branch redirects and restarts from RESET_PC whenever the selected program (prog_type) changes.

Parameters:
ADDR_W, `INST_RAM_WIDTH, byte-address width of the instruction RAM
RESET_PC, 0, PC after reset, program switch and restart

Ports:
clk  in  1  system clock; all state updates on posedge
clr  in  1  reset, asynchronous, active-high
run  in  1  fetch enable; 0 holds in IDLE
prog_type  in  `PROG_TYPE_WIDTH  selected program, forwarded to the RAM
ram_prog_type  out  `PROG_TYPE_WIDTH  registered prog_type to the RAM
re  out  1  RAM read enable
read_addr  out  ADDR_W  RAM byte address, always equal to pc
read_data  in  32  RAM read word
read_finished  in  1  RAM read-complete flag; RAM updates it on negedge
redirect_valid  in  1  branch/jump redirect, one-cycle pulse
redirect_pc  in  ADDR_W  redirect target
inst  out  32  fetched instruction
inst_pc  out  ADDR_W  address of inst
inst_valid  out  1  inst/inst_pc valid
inst_ready  in  1  decode accepts
halted  out  1  see Optional Feature

Behaviour:
- Reset (clr=1, asynchronous): state=IDLE, pc=RESET_PC, re=0, inst=0, inst_pc=0, inst_valid=0, halted=0, ram_prog_type=prog_type sampled at the first posedge after release (reset value 0).
- States: IDLE (re=0), REQ (re=1), VALID (re=0, inst_valid=1).
- IDLE -> REQ on posedge when run=1 and no flush.
- REQ: read_addr=pc held stable. On the posedge with read_finished=1: inst<=read_data, inst_pc<=pc, -> VALID. read_finished is never sampled in the first REQ cycle before a negedge has occurred. Entry from IDLE/VALID guarantees re was 0 for at least one negedge, so a stale read_finished=1 is never seen.
- VALID: on posedge with inst_ready=1: pc<=pc+4 (wraps modulo 2^ADDR_W), inst_valid<=0, -> REQ if run=1, else IDLE. If inst_ready=0, inst/inst_pc held unchanged.
- Latency: REQ entry to inst_valid is 1 cycle. Steady-state throughput with inst_ready=1 is 1 instruction per 2 cycles.
- Redirect (redirect_valid=1, any state): pc<=redirect_pc with bits [1:0] forced to 0; inst_valid<=0; -> IDLE. A read_finished in the same cycle is discarded. A held VALID instruction is dropped even if inst_ready=1 that cycle.
- Program switch: if prog_type != ram_prog_type at a posedge: ram_prog_type<=prog_type, pc<=RESET_PC, inst_valid<=0, -> IDLE.
- Priority: clr > program switch > redirect > normal flow.
- run=0 in REQ: the current access completes and is delivered. run only gates leaving IDLE and VALID.
- read_addr is combinationally pc. re is a registered/state-decoded output, glitch-free.

Optional Feature:
Macro FETCH_HALT_EN.
- Defined: when an accepted instruction (VALID && inst_ready) equals 32'h0000_0073, halted<=1 and the FSM goes to IDLE without advancing further. halted stays 1 until clr, program switch or redirect clears it, each returning to normal flow. While halted=1, IDLE ignores run.
- Undefined: halted is tied to 0 and 32'h0000_0073 is fetched like any other word.

Test Plan:
- Reset release, run=1, RAM word at 0 = 32'h1234_5678, inst_ready=1 -> inst_valid at cycle 2 with inst=32'h1234_5678, inst_pc=0; next inst_pc=4 two cycles later; re low for exactly one cycle between accesses.
- inst_ready=0 for 5 cycles while VALID -> inst/inst_pc stable, re=0, pc unchanged; ready=1 -> pc advances by 4.
- redirect_valid with redirect_pc=0x23 during REQ while read_finished=1 -> old word discarded, next fetch read_addr=0x20, inst_pc=0x20.
- prog_type changes from LED to FIB mid-stream at pc=0x40 -> inst_valid drops, ram_prog_type updates, next read_addr=RESET_PC.
- pc=2^ADDR_W-4 accepted -> pc wraps to 0.
- FETCH_HALT_EN defined, word 32'h0000_0073 at 0x8 accepted -> halted=1, no further re; redirect to 0 -> halted=0 and fetching resumes.
